// File: rtl/mips_pkg.sv
// Shared decode constants and control bundle for the MIPS single-cycle core.
// Optional bne decode is enabled by defining MIPS_BNE_EN.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALUC_AND  = 4'b0000;
    localparam logic [3:0] ALUC_OR   = 4'b0001;
    localparam logic [3:0] ALUC_ADD  = 4'b0010;
    localparam logic [3:0] ALUC_SUB  = 4'b0110;
    localparam logic [3:0] ALUC_SLT  = 4'b0111;
    localparam logic [3:0] ALUC_NOR  = 4'b1100;
    // Unknown R-type funct: ALU forces a zero result.
    localparam logic [3:0] ALUC_ZERO = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       jump;
        logic       branch;
        logic       branch_ne;
        logic       mem_read;
        logic       mem_to_reg;
        logic [1:0] alu_op;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
    } ctrl_t;

endpackage

// File: rtl/mips_alu.sv
// 32-bit ALU: and/or/add/sub/slt/nor selected by ALUControl.
// Add/sub wrap silently; Zero flags an all-zero result.
module mips_alu
    import mips_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_ctrl,
    output logic [31:0] o_result,
    output logic        o_zero
);

    // Operation select.
    always_comb begin
        o_result = 32'd0;
        case (i_ctrl)
            ALUC_AND: o_result = i_a & i_b;
            ALUC_OR:  o_result = i_a | i_b;
            ALUC_ADD: o_result = i_a + i_b;
            ALUC_SUB: o_result = i_a - i_b;
            ALUC_SLT: o_result = {31'd0, $signed(i_a) < $signed(i_b)};
            ALUC_NOR: o_result = ~(i_a | i_b);
            default:  o_result = 32'd0;
        endcase
    end

    assign o_zero = (o_result == 32'd0);

endmodule

// File: rtl/mips_single_cycle_core.sv
// Single-cycle MIPS subset core with init-loaded instruction/data memories.
// Define MIPS_BNE_EN to decode opcode 000101 as bne; otherwise it is a NOP.
module mips_single_cycle_core
    import mips_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_write_enable,
    input  logic [7:0]  instr_write_addr,
    input  logic [31:0] instr_write_data,
    input  logic        data_init_write_enable,
    input  logic [7:0]  data_init_addr,
    input  logic [31:0] data_init_data,
    output logic [31:0] RegValue0,  RegValue1,  RegValue2,  RegValue3,
    output logic [31:0] RegValue4,  RegValue5,  RegValue6,  RegValue7,
    output logic [31:0] RegValue8,  RegValue9,  RegValue10, RegValue11,
    output logic [31:0] RegValue12, RegValue13, RegValue14, RegValue15,
    output logic [31:0] RegValue16, RegValue17, RegValue18, RegValue19,
    output logic [31:0] RegValue20, RegValue21, RegValue22, RegValue23,
    output logic [31:0] RegValue24, RegValue25, RegValue26, RegValue27,
    output logic [31:0] RegValue28, RegValue29, RegValue30, RegValue31
);

    logic [31:0] r_pc;
    logic [31:0] r_imem [IMEM_WORDS];
    logic [31:0] r_dmem [DMEM_WORDS];
    logic [31:0] r_regs [32];

    logic [31:0] w_instr;
    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_write_reg;
    logic [31:0] w_imm;
    logic [31:0] w_rs_data;
    logic [31:0] w_rt_data;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_result;
    logic        w_zero;
    logic [3:0]  w_alu_ctrl;
    logic [31:0] w_mem_rdata;
    logic [31:0] w_wb_data;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic        w_take_branch;
    ctrl_t       w_ctrl;

    assign w_instr     = r_imem[r_pc[9:2]];
    assign w_opcode    = w_instr[31:26];
    assign w_rs        = w_instr[25:21];
    assign w_rt        = w_instr[20:16];
    assign w_rd        = w_instr[15:11];
    assign w_funct     = w_instr[5:0];
    assign w_imm       = {{16{w_instr[15]}}, w_instr[15:0]};
    assign w_write_reg = w_ctrl.reg_dst ? w_rd : w_rt;

    // Main control decode; unrecognised opcodes leave every control low.
    always_comb begin
        w_ctrl = '0;
        case (w_opcode)
            OP_RTYPE: begin
                w_ctrl.reg_dst   = 1'b1;
                w_ctrl.alu_op    = ALUOP_FUNCT;
                w_ctrl.reg_write = 1'b1;
            end
            OP_LW: begin
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
            end
            OP_SW: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            OP_ADDI: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OP_BEQ: begin
                w_ctrl.branch = 1'b1;
                w_ctrl.alu_op = ALUOP_SUB;
            end
`ifdef MIPS_BNE_EN
            OP_BNE: begin
                w_ctrl.branch    = 1'b1;
                w_ctrl.branch_ne = 1'b1;
                w_ctrl.alu_op    = ALUOP_SUB;
            end
`endif
            OP_J: w_ctrl.jump = 1'b1;
            default: ;
        endcase
    end

    // ALU control from ALUOp and funct.
    always_comb begin
        w_alu_ctrl = ALUC_ADD;
        case (w_ctrl.alu_op)
            ALUOP_SUB: w_alu_ctrl = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (w_funct)
                    FN_ADD:  w_alu_ctrl = ALUC_ADD;
                    FN_SUB:  w_alu_ctrl = ALUC_SUB;
                    FN_AND:  w_alu_ctrl = ALUC_AND;
                    FN_OR:   w_alu_ctrl = ALUC_OR;
                    FN_NOR:  w_alu_ctrl = ALUC_NOR;
                    FN_SLT:  w_alu_ctrl = ALUC_SLT;
                    default: w_alu_ctrl = ALUC_ZERO;
                endcase
            end
            default: w_alu_ctrl = ALUC_ADD;
        endcase
    end

    assign w_rs_data = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
    assign w_rt_data = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];
    assign w_alu_b   = w_ctrl.alu_src ? w_imm : w_rt_data;

    mips_alu u_alu (
        .i_a      (w_rs_data),
        .i_b      (w_alu_b),
        .i_ctrl   (w_alu_ctrl),
        .o_result (w_alu_result),
        .o_zero   (w_zero)
    );

    assign w_mem_rdata = w_ctrl.mem_read ? r_dmem[w_alu_result[9:2]] : 32'd0;
    assign w_wb_data   = w_ctrl.mem_to_reg ? w_mem_rdata : w_alu_result;

    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_take_branch = w_ctrl.branch & (w_zero ^ w_ctrl.branch_ne);

    // Next-PC select: jump, taken branch, or fall-through.
    always_comb begin
        w_pc_next = w_pc_plus4;
        if (w_ctrl.jump) begin
            w_pc_next = {w_pc_plus4[31:28], w_instr[25:0], 2'b00};
        end else if (w_take_branch) begin
            w_pc_next = w_pc_plus4 + {w_imm[29:0], 2'b00};
        end
    end

    // Program counter.
    always_ff @(posedge clk) begin
        if (reset) r_pc <= 32'd0;
        else       r_pc <= w_pc_next;
    end

    // Register file write port; $0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
        end else if (w_ctrl.reg_write && (w_write_reg != 5'd0)) begin
            r_regs[w_write_reg] <= w_wb_data;
        end
    end

    // Instruction memory load port.
    always_ff @(posedge clk) begin
        if (instr_write_enable) r_imem[instr_write_addr] <= instr_write_data;
    end

    // Data memory: init port has priority over a store on the same edge.
    always_ff @(posedge clk) begin
        if (data_init_write_enable) begin
            r_dmem[data_init_addr] <= data_init_data;
        end else if (w_ctrl.mem_write && !reset) begin
            r_dmem[w_alu_result[9:2]] <= w_rt_data;
        end
    end

    assign RegValue0  = 32'd0;
    assign RegValue1  = r_regs[1];
    assign RegValue2  = r_regs[2];
    assign RegValue3  = r_regs[3];
    assign RegValue4  = r_regs[4];
    assign RegValue5  = r_regs[5];
    assign RegValue6  = r_regs[6];
    assign RegValue7  = r_regs[7];
    assign RegValue8  = r_regs[8];
    assign RegValue9  = r_regs[9];
    assign RegValue10 = r_regs[10];
    assign RegValue11 = r_regs[11];
    assign RegValue12 = r_regs[12];
    assign RegValue13 = r_regs[13];
    assign RegValue14 = r_regs[14];
    assign RegValue15 = r_regs[15];
    assign RegValue16 = r_regs[16];
    assign RegValue17 = r_regs[17];
    assign RegValue18 = r_regs[18];
    assign RegValue19 = r_regs[19];
    assign RegValue20 = r_regs[20];
    assign RegValue21 = r_regs[21];
    assign RegValue22 = r_regs[22];
    assign RegValue23 = r_regs[23];
    assign RegValue24 = r_regs[24];
    assign RegValue25 = r_regs[25];
    assign RegValue26 = r_regs[26];
    assign RegValue27 = r_regs[27];
    assign RegValue28 = r_regs[28];
    assign RegValue29 = r_regs[29];
    assign RegValue30 = r_regs[30];
    assign RegValue31 = r_regs[31];

endmodule

// File: tb/tb_mips_single_cycle_core.sv
// Scoreboard bench for mips_single_cycle_core.
// Expected register values are queued with each program and drained after it runs.
module tb_mips_single_cycle_core;

    logic        clk;
    logic        reset;
    logic        instr_write_enable;
    logic [7:0]  instr_write_addr;
    logic [31:0] instr_write_data;
    logic        data_init_write_enable;
    logic [7:0]  data_init_addr;
    logic [31:0] data_init_data;
    wire  [31:0] rv [32];

    typedef struct {
        string       tag;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] prog [26];

    mips_single_cycle_core dut (
        .clk                    (clk),
        .reset                  (reset),
        .instr_write_enable     (instr_write_enable),
        .instr_write_addr       (instr_write_addr),
        .instr_write_data       (instr_write_data),
        .data_init_write_enable (data_init_write_enable),
        .data_init_addr         (data_init_addr),
        .data_init_data         (data_init_data),
        .RegValue0  (rv[0]),  .RegValue1  (rv[1]),
        .RegValue2  (rv[2]),  .RegValue3  (rv[3]),
        .RegValue4  (rv[4]),  .RegValue5  (rv[5]),
        .RegValue6  (rv[6]),  .RegValue7  (rv[7]),
        .RegValue8  (rv[8]),  .RegValue9  (rv[9]),
        .RegValue10 (rv[10]), .RegValue11 (rv[11]),
        .RegValue12 (rv[12]), .RegValue13 (rv[13]),
        .RegValue14 (rv[14]), .RegValue15 (rv[15]),
        .RegValue16 (rv[16]), .RegValue17 (rv[17]),
        .RegValue18 (rv[18]), .RegValue19 (rv[19]),
        .RegValue20 (rv[20]), .RegValue21 (rv[21]),
        .RegValue22 (rv[22]), .RegValue23 (rv[23]),
        .RegValue24 (rv[24]), .RegValue25 (rv[25]),
        .RegValue26 (rv[26]), .RegValue27 (rv[27]),
        .RegValue28 (rv[28]), .RegValue29 (rv[29]),
        .RegValue30 (rv[30]), .RegValue31 (rv[31])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int idx, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.idx = idx;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, rv[e.idx], e.val);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        prog[0]  = 32'h20010005; // addi $1,$0,5
        prog[1]  = 32'h20020007; // addi $2,$0,7
        prog[2]  = 32'h00221820; // add  $3,$1,$2
        prog[3]  = 32'h00222022; // sub  $4,$1,$2
        prog[4]  = 32'h0022282A; // slt  $5,$1,$2
        prog[5]  = 32'h8C060190; // lw   $6,400($0)
        prog[6]  = 32'hAC060194; // sw   $6,404($0)
        prog[7]  = 32'h8C070194; // lw   $7,404($0)
        prog[8]  = 32'h10210002; // beq  $1,$1,+2
        prog[9]  = 32'h20080063; // skipped
        prog[10] = 32'h20080062; // skipped
        prog[11] = 32'h10220001; // beq  $1,$2,+1 (not taken)
        prog[12] = 32'h2009FFFF; // addi $9,$0,-1
        prog[13] = 32'h00225027; // nor  $10,$1,$2
        prog[14] = 32'h00225824; // and  $11,$1,$2
        prog[15] = 32'h00226025; // or   $12,$1,$2
        prog[16] = 32'h0022483F; // bad funct -> $9=0
        prog[17] = 32'h200DFFFF; // addi $13,$0,-1
        prog[18] = 32'h20000009; // addi $0,$0,9
        prog[19] = 32'h14220001; // bne  $1,$2,+1
        prog[20] = 32'h200E0001; // addi $14,$0,1
        prog[21] = 32'hFC000000; // unknown opcode
        prog[22] = 32'h08000018; // j 24
        prog[23] = 32'h200F0003; // skipped
        prog[24] = 32'h20100055; // addi $16,$0,0x55
        prog[25] = 32'h08000019; // j 25 (halt loop)

        reset = 1'b1;
        instr_write_enable = 1'b0;
        instr_write_addr = 8'd0;
        instr_write_data = 32'd0;
        data_init_write_enable = 1'b0;
        data_init_addr = 8'd0;
        data_init_data = 32'd0;
        step(2);

        for (int i = 0; i < 26; i++) begin
            instr_write_enable = 1'b1;
            instr_write_addr = 8'(i);
            instr_write_data = prog[i];
            step(1);
        end
        instr_write_enable = 1'b0;
        data_init_write_enable = 1'b1;
        data_init_addr = 8'd100;
        data_init_data = 32'h00001234;
        step(1);
        data_init_write_enable = 1'b0;

        push("rst_r1", 1, 32'd0);
        push("rst_r31", 31, 32'd0);
        drain();

        reset = 1'b0;
        push("first_r1", 1, 32'd5);
        push("first_r2", 2, 32'd0);
        push("first_r0", 0, 32'd0);
        step(1);
        drain();

        push("add_r3", 3, 32'd12);
        push("sub_r4", 4, 32'hFFFFFFFE);
        push("slt_r5", 5, 32'd1);
        push("lw_r6", 6, 32'h00001234);
        push("lw_r7", 7, 32'h00001234);
        push("beq_skip_r8", 8, 32'd0);
        push("badfn_r9", 9, 32'd0);
        push("nor_r10", 10, 32'hFFFFFFF8);
        push("and_r11", 11, 32'd5);
        push("or_r12", 12, 32'd7);
        push("sext_r13", 13, 32'hFFFFFFFF);
        push("zero_r0", 0, 32'd0);
`ifdef MIPS_BNE_EN
        push("bne_r14", 14, 32'd0);
`else
        push("bne_r14", 14, 32'd1);
`endif
        push("j_skip_r15", 15, 32'd0);
        push("j_tgt_r16", 16, 32'h00000055);
        push("keep_r1", 1, 32'd5);
        push("keep_r2", 2, 32'd7);
        step(40);
        drain();

        reset = 1'b1;
        instr_write_enable = 1'b1;
        instr_write_addr = 8'd0;
        instr_write_data = 32'h8C140194; // lw $20,404($0)
        for (int i = 0; i < 32; i++) begin
            push($sformatf("mid_rst_r%0d", i), i, 32'd0);
        end
        step(1);
        instr_write_enable = 1'b0;
        drain();

        reset = 1'b0;
        push("rerun_r20", 20, 32'h00001234);
        push("rerun_r1", 1, 32'd0);
        step(1);
        drain();

        push("rerun2_r2", 2, 32'd7);
        step(1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_single_cycle_core.md
Name: mips_single_cycle_core

Overview:
Single-cycle 32-bit MIPS subset processor that executes one instruction per clock.
Contains a word-addressed instruction memory and data memory, a 32x32 register file, an ALU, and main plus ALU control decode.
Both memories are loaded through dedicated init ports while the core is held in reset.
All 32 architectural registers are exported for debug and observation.

Parameters:
IMEM_WORDS, 256, instruction memory depth in 32-bit words (index width 8).
DMEM_WORDS, 256, data memory depth in 32-bit words (index width 8).

Ports:
clk  in  1  single clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
instr_write_enable  in  1  write instr_write_data into instruction memory this edge.
instr_write_addr  in  8  instruction memory word index.
instr_write_data  in  32  instruction word to store.
data_init_write_enable  in  1  write data_init_data into data memory this edge.
data_init_addr  in  8  data memory word index.
data_init_data  in  32  data word to store.
RegValue0..RegValue31  out  32 each  current contents of registers $0..$31, combinational from the register file.

Behaviour:
- Reset (sync, high): PC<=0; registers $1..$31 <=0. Memories are not cleared. Init-port writes are honoured in any cycle, reset or not.
- Fetch: instruction = imem[PC[9:2]] (async read). PC is 32-bit; the memory index wraps modulo 256 words.
- Supported opcodes (unrecognised = NOP, PC+4, no writes):
  - R-type 000000: funct 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt (signed).
  - lw 100011, sw 101011, addi 001000, beq 000100, j 000010.
  - Unknown R-type funct writes 0 to rd.
- Main control outputs: RegDst, Jump, Branch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite.
  - ALUOp: 00=add (lw/sw/addi), 01=sub (beq), 10=use funct.
- ALUControl[3:0] encoding: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1100 nor.
- ALU:
  - Zero=1 when result==0.
  - Add/sub wrap mod 2^32 with no overflow trap.
  - Immediate is sign-extended.
- Register file:
  - Two async read ports.
  - Write on rising edge when RegWrite and not reset.
  - WriteReg = rd if RegDst, else rt.
  - Writes to $0 are ignored; $0 always reads 0.
  - A read in the same cycle as a write returns the old value.
- Data memory:
  - Byte address = ALUResult; word index = ALUResult[9:2], low bits ignored.
  - Async read; sw writes on rising edge.
  - If data_init_write_enable and sw target the same edge, the init port wins.
- Write-back: WriteData = mem read data if MemtoReg, else ALUResult.
- Next PC:
  - j: {PC+4[31:28], target, 00}.
  - beq taken (Branch & Zero): PC+4 + (signext(imm)<<2).
  - Otherwise: PC+4.
  - During reset the next PC is 0.
- Memory writes, register writes and PC updates all occur in the same cycle. There are no stalls or hazards.

Optional Feature:
Macro MIPS_BNE_EN.
- Defined: opcode 000101 (bne) decodes as a branch with ALUOp=01; it is taken when Zero==0.
- Undefined: 000101 is a NOP.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct localparams;
  - ALUControl encodings;
  - ALUOp encodings;
  - a control-signal struct typedef.
- One natural sub-module, mips_alu: operands A and B, ALUControl in; Result and Zero out.
- Control, register file and memories stay in the top level.

Test Plan:
1. Hold reset and load imem[0]=addi $1,$0,5 (0x20010005), then release reset. -> After 1 cycle $1=5 and PC=4. RegValue0 stays 0.
2. addi $2,$0,7; add $3,$1,$2; sub $4,$1,$2; slt $5,$1,$2. -> $3=12, $4=0xFFFFFFFE, $5=1.
3. Init dmem[100]=0x1234. Run lw $6,400($0), then sw $6,404($0), then lw $7,404($0). -> $6=$7=0x1234 and dmem[101]=0x1234.
4. beq $1,$1,+2 at PC=8. -> Next PC=20. beq with unequal operands -> PC=12.
5. j 0 at PC=16. -> Next PC=0.
6. Assert reset mid-program. -> On the next edge PC=0 and all RegValue outputs are 0; memory contents are retained. addi $0,$0,9 leaves $0=0.
